// File: rtl/abs_diff_err_pkg.sv
// Shared types and helpers for the |a-b| error monitor: sweep state
// encoding, default widths and the exact absolute-difference reference.
package abs_diff_err_pkg;

   localparam int OP_W_DEF  = 4;
   localparam int OUT_W_DEF = 5;
   localparam int ET_DEF    = 16;
   localparam int DEPTH_DEF = 4;

   // Working width of the reference function; callers cast in and out.
   localparam int AD_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [AD_W-1:0] abs_diff(input logic [AD_W-1:0] x,
                                                input logic [AD_W-1:0] y);
      return (x >= y) ? (x - y) : (y - x);
   endfunction

endpackage

// File: rtl/abs_diff_exp_fifo.sv
// Synchronous FIFO holding expected results for vectors still in flight in
// the circuit under evaluation. It is only a handful of entries deep and
// the head must be visible in the same cycle a result arrives, so the read
// port is asynchronous (distributed storage rather than block RAM).
module abs_diff_exp_fifo #(
   parameter int DW    = 5,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DW-1:0]            push_data,
   input  logic                     pop,
   output logic [DW-1:0]            pop_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   // Next pointers and occupancy; a simultaneous push and pop leaves the count alone.
   always_comb begin
      do_push  = push && (count_q != FULL_CNT);
      do_pop   = pop && (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents need no reset because occupancy guards every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

   assign pop_data = mem[rd_ptr_q];
   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign count    = count_q;

endmodule

// File: rtl/abs_diff_err_monitor.sv
// Exhaustive error evaluator for approximate |a-b| circuits. Sweeps every
// {b,a} input vector into the circuit, pairs each returned result with the
// exact |a-b| queued at issue time, and accumulates worst-case error, error
// sum and threshold-violation count.
// Optional build macro ABS_DIFF_ERR_FAIL_CAPTURE_EN adds fail_seen/fail_vec/
// fail_err, recording the first violating vector in issue order.
module abs_diff_err_monitor
   import abs_diff_err_pkg::*;
#(
   parameter int OP_W  = OP_W_DEF,
   parameter int OUT_W = OUT_W_DEF,
   parameter int ET    = ET_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic                      vec_valid,
   input  logic                      vec_ready,
   output logic [2*OP_W-1:0]         vec,
   input  logic                      res_valid,
   input  logic [OUT_W-1:0]          dut_out,
   output logic                      busy,
   output logic                      done,
   output logic [OUT_W-1:0]          max_err,
   output logic [2*OP_W+OUT_W-1:0]   err_sum,
   output logic [2*OP_W:0]           viol_cnt,
   output logic                      pass,
   output logic                      proto_err
`ifdef ABS_DIFF_ERR_FAIL_CAPTURE_EN
   ,
   output logic                      fail_seen,
   output logic [2*OP_W-1:0]         fail_vec,
   output logic [OUT_W-1:0]          fail_err
`endif
);

   localparam int VEC_W = 2*OP_W;
   localparam int SUM_W = 2*OP_W + OUT_W;
   localparam int VC_W  = 2*OP_W + 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef ABS_DIFF_ERR_FAIL_CAPTURE_EN
   localparam int FIFO_DW = VEC_W + OUT_W;
`else
   localparam int FIFO_DW = OUT_W;
`endif
   localparam logic [OUT_W:0] ET_CMP = (OUT_W+1)'(ET);

   state_t           state_q, state_d;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic [OUT_W-1:0] max_err_q, max_err_d;
   logic [SUM_W-1:0] err_sum_q, err_sum_d;
   logic [VC_W-1:0]  viol_cnt_q, viol_cnt_d;
   logic             proto_err_q, proto_err_d;

   logic               issue_hs, start_ok, pop_ok, viol;
   logic [OUT_W-1:0]   exp_push, exp_pop, err;
   logic [FIFO_DW-1:0] fifo_wr, fifo_rd;
   logic               fifo_empty, fifo_full;
   logic [CNT_W-1:0]   fifo_count;

`ifdef ABS_DIFF_ERR_FAIL_CAPTURE_EN
   logic             fail_seen_q, fail_seen_d;
   logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
   logic [OUT_W-1:0] fail_err_q, fail_err_d;
   logic [VEC_W-1:0] idx_pop;
`endif

   // Handshakes, exact reference for the vector being issued and error of the retiring result.
   always_comb begin
      issue_hs = vec_valid && vec_ready;
      start_ok = start && ((state_q == IDLE) || (state_q == DONE));
      pop_ok   = res_valid && !fifo_empty;
      exp_push = OUT_W'(abs_diff(AD_W'(vec_q[OP_W-1:0]), AD_W'(vec_q[VEC_W-1:OP_W])));
      exp_pop  = fifo_rd[OUT_W-1:0];
`ifdef ABS_DIFF_ERR_FAIL_CAPTURE_EN
      fifo_wr  = {vec_q, exp_push};
      idx_pop  = fifo_rd[FIFO_DW-1:OUT_W];
`else
      fifo_wr  = exp_push;
`endif
      err      = (dut_out >= exp_pop) ? (dut_out - exp_pop) : (exp_pop - dut_out);
      viol     = ({1'b0, err} > ET_CMP);
   end

   abs_diff_exp_fifo #(
      .DW    (FIFO_DW),
      .DEPTH (DEPTH)
   ) u_exp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (issue_hs),
      .push_data (fifo_wr),
      .pop       (pop_ok),
      .pop_data  (fifo_rd),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   // Sweep sequencing: issue every vector once, then wait for the pipeline to empty.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      case (state_q)
         IDLE, DONE: begin
            if (start_ok) begin
               state_d = RUN;
               vec_d   = '0;
            end
         end
         RUN: begin
            if (issue_hs) begin
               vec_d = vec_q + VEC_W'(1);
               if (vec_q == '1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Count is registered, so this only fires once the final pop has landed.
            if (fifo_count == '0) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Statistics update on each retired result; a new start clears everything in the same edge.
   always_comb begin
      max_err_d   = max_err_q;
      err_sum_d   = err_sum_q;
      viol_cnt_d  = viol_cnt_q;
      proto_err_d = proto_err_q;
`ifdef ABS_DIFF_ERR_FAIL_CAPTURE_EN
      fail_seen_d = fail_seen_q;
      fail_vec_d  = fail_vec_q;
      fail_err_d  = fail_err_q;
`endif
      if (pop_ok) begin
         if (err > max_err_q) max_err_d = err;
         err_sum_d = err_sum_q + SUM_W'(err);
         if (viol) viol_cnt_d = viol_cnt_q + VC_W'(1);
`ifdef ABS_DIFF_ERR_FAIL_CAPTURE_EN
         if (viol && !fail_seen_q) begin
            fail_seen_d = 1'b1;
            fail_vec_d  = idx_pop;
            fail_err_d  = err;
         end
`endif
      end
      // A result with nothing outstanding cannot be paired; flag it and drop it.
      if (res_valid && fifo_empty) proto_err_d = 1'b1;
      if (start_ok) begin
         max_err_d   = '0;
         err_sum_d   = '0;
         viol_cnt_d  = '0;
         proto_err_d = 1'b0;
`ifdef ABS_DIFF_ERR_FAIL_CAPTURE_EN
         fail_seen_d = 1'b0;
         fail_vec_d  = '0;
         fail_err_d  = '0;
`endif
      end
   end

   // State, vector counter and statistics registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vec_q       <= '0;
         max_err_q   <= '0;
         err_sum_q   <= '0;
         viol_cnt_q  <= '0;
         proto_err_q <= 1'b0;
`ifdef ABS_DIFF_ERR_FAIL_CAPTURE_EN
         fail_seen_q <= 1'b0;
         fail_vec_q  <= '0;
         fail_err_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         max_err_q   <= max_err_d;
         err_sum_q   <= err_sum_d;
         viol_cnt_q  <= viol_cnt_d;
         proto_err_q <= proto_err_d;
`ifdef ABS_DIFF_ERR_FAIL_CAPTURE_EN
         fail_seen_q <= fail_seen_d;
         fail_vec_q  <= fail_vec_d;
         fail_err_q  <= fail_err_d;
`endif
      end
   end

   assign vec_valid = (state_q == RUN) && !fifo_full;
   assign vec       = vec_q;
   assign busy      = (state_q == RUN) || (state_q == DRAIN);
   assign done      = (state_q == DONE);
   assign max_err   = max_err_q;
   assign err_sum   = err_sum_q;
   assign viol_cnt  = viol_cnt_q;
   assign pass      = (state_q == DONE) && (viol_cnt_q == '0);
   assign proto_err = proto_err_q;
`ifdef ABS_DIFF_ERR_FAIL_CAPTURE_EN
   assign fail_seen = fail_seen_q;
   assign fail_vec  = fail_vec_q;
   assign fail_err  = fail_err_q;
`endif

endmodule
